// File: rtl/load_store_unit.sv
// load_store_unit: accepts one load or store at a time from the execute stage,
// issues a single word-aligned memory request, and returns a one-cycle done
// pulse together with an error flag.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   valid_in            execute stage presents an operation
//   mem_read/mem_write  load / store select (exactly one must be set)
//   funct3              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_result          effective byte address
//   rdata2              store data
//   busy                unit is in ACCESS or RESP
//   done, err           completion pulse and its error qualifier
//   load_data           formatted result of the last successful load
//   mem_req/mem_we      memory request and direction (held until mem_ready)
//   mem_addr            word address {addr[31:2],2'b00}
//   mem_wdata/mem_wstrb lane-replicated store data and byte enables
//   mem_ready/mem_rdata memory handshake and read word
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_err_pend;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_bad;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;

    // Request decode for the operation presented in IDLE
    always_comb begin
        w_accept     = valid_in && (mem_read || mem_write);
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_wstrb      = 4'b1111;
        w_wdata      = rdata2;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = mem_write;  // unsigned sizes are load-only
            default:                w_illegal = 1'b1;
        endcase
        if (funct3[1:0] == 2'b01 && alu_result[0])
            w_misaligned = 1'b1;
        if (funct3 == 3'b010 && alu_result[1:0] != 2'b00)
            w_misaligned = 1'b1;
        w_bad = (mem_read && mem_write) || w_illegal || w_misaligned;
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << alu_result[1:0];
                w_wdata = {4{rdata2[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << alu_result[1:0];
                w_wdata = {2{rdata2[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = rdata2;
            end
        endcase
    end

    // Lane selection and extension of the returned word
    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_err_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            load_data  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= funct3;
                        r_off    <= alu_result[1:0];
                        busy     <= 1'b1;
                        if (w_bad) begin
                            r_state    <= RESP;
                            r_err_pend <= 1'b1;
                        end else begin
                            r_state    <= ACCESS;
                            r_err_pend <= 1'b0;
                            r_cnt      <= '0;
                            mem_req    <= 1'b1;
                            mem_we     <= mem_write;
                            mem_addr   <= {alu_result[31:2], 2'b00};
                            mem_wdata  <= mem_write ? w_wdata : '0;
                            mem_wstrb  <= mem_write ? w_wstrb : 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    // A ready arriving on the last permitted cycle still completes
                    if (mem_ready) begin
                        r_state <= RESP;
                        mem_req <= 1'b0;
                        if (!mem_we)
                            load_data <= w_load_fmt;
                    end else if (r_cnt == LP_LAST) begin
                        r_state    <= RESP;
                        mem_req    <= 1'b0;
                        r_err_pend <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RESP: begin
                    // done/err are registered on the edge leaving RESP
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    err     <= r_err_pend;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum ACCESS-state cycles to wait for mem_ready before aborting; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 valid_in  input  1  execute stage presents an operation this cycle.
REQ-005 mem_read  input  1  operation is a load.
REQ-006 mem_write  input  1  operation is a store.
REQ-007 funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
REQ-008 alu_result  input  32  effective address from the ALU (rdata1+imm).
REQ-009 rdata2  input  32  store data from the register file.
REQ-010 busy  output  1  unit is not in IDLE; upstream holds the pipeline.
REQ-011 done  output  1  one-cycle pulse: operation complete (load, store or error).
REQ-012 err  output  1  valid only with done; misaligned/illegal/timeout.
REQ-013 load_data  output  32  formatted load result, held until the next successful load.
REQ-014 mem_req  output  1  memory request, held until accepted.
REQ-015 mem_we  output  1  1 = write.
REQ-016 mem_addr  output  32  word address: {addr[31:2],2'b00}.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_wstrb  output  4  byte enables; 0000 on reads.
REQ-019 mem_ready  input  1  memory accepts/completes the request this cycle.
REQ-020 mem_rdata  input  32  read word, valid when mem_ready=1 and mem_we=0.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS, RESP; all outputs are registered.
REQ-022 In IDLE, valid_in=1 with exactly one of mem_read/mem_write set SHALL be accepted; address, data, funct3 and direction are captured.
REQ-023 Accepted legal, aligned operations SHALL go to ACCESS with mem_req=1 from the next cycle.
REQ-024 Misaligned (H with addr[0]=1, W with addr[1:0]!=0), illegal funct3, or mem_read=mem_write=1 with valid_in SHALL go directly to RESP with err=1 and no mem_req.
REQ-025 valid_in with both mem_read and mem_write low SHALL be ignored (no state change, no done).
REQ-026 valid_in while busy=1 SHALL be ignored.
REQ-027 In ACCESS, mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb SHALL remain stable until mem_ready=1 is sampled.
REQ-028 When mem_ready=1 is sampled in ACCESS, the FSM SHALL go to RESP and deassert mem_req on the same edge; loads update load_data on that edge.
REQ-029 A cycle counter SHALL start at 0 on entry to ACCESS; if TIMEOUT cycles elapse without mem_ready, the FSM SHALL go to RESP with err=1 and load_data unchanged.
REQ-030 RESP SHALL last exactly one cycle with done=1 and then return to IDLE; best-case latency is acceptance edge +2 edges to done.
REQ-031 Store SB: wstrb=0001<<addr[1:0], wdata={4{rdata2[7:0]}}; SH: wstrb=0011<<addr[1:0], wdata={2{rdata2[15:0]}}; SW: wstrb=1111, wdata=rdata2.
REQ-032 Load byte SHALL select mem_rdata[8*addr[1:0]+:8]; halfword SHALL select mem_rdata[16*addr[1]+:16]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-033 busy SHALL be 1 in ACCESS and RESP, 0 in IDLE.

Reset
REQ-034 rst=1 at an edge SHALL force IDLE, clear the counter, and set busy, done, err, mem_req, mem_we, mem_wstrb to 0 and load_data, mem_addr, mem_wdata to 0.
REQ-035 Reset during ACCESS SHALL drop mem_req on that edge and produce no done pulse.

Verification
REQ-036 LW addr 0x100, mem_ready=1 on the first req cycle, mem_rdata 0xDEADBEEF -> mem_addr 0x100, done two edges after acceptance, load_data 0xDEADBEEF, err=0.
REQ-037 LB addr 0x103, mem_rdata 0x80FF1234 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-038 SH addr 0x0A, rdata2 0x1234ABCD, mem_ready delayed 3 cycles -> mem_addr 0x08, wstrb 1100, wdata 0xABCDABCD, stable for all 4 req cycles, then done.
REQ-039 LW addr 0x102 -> no mem_req, done=1 and err=1 one edge after acceptance; load_data unchanged.
REQ-040 TIMEOUT=4, mem_ready held 0 -> mem_req high for exactly 4 cycles, then done=1, err=1.
REQ-041 rst asserted in the 2nd cycle of a pending SW -> mem_req=0 and busy=0 after that edge, no done; the next LW completes normally.
